pwm_capture: RTL and testbench

- Receive-side counterpart of the team's PWM LED generator. It measures an incoming PWM waveform and reports period and high time in clk cycles.
- Used to loop back generator outputs for self-test, and to read external PWM sources through the AXI register block.
- Detects a stuck-low or stuck-high input with a timeout.

---
 rtl/pwm_capture.sv | 223 ++++++++++++++++++++++
 tb/tb_pwm_capture.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous PWM input in clk cycles and
// flags a stuck input with a timeout.
// Optional glitch filter on the synchronized input is enabled by defining PWM_CAP_FILTER_EN.
module pwm_capture #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned TIMEOUT    = 1000000,
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             stuck,
  output logic             stuck_level,
  output logic             busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StArm  = 2'd1;
  localparam logic [1:0] StHigh = 2'd2;
  localparam logic [1:0] StLow  = 2'd3;

  // Timeout fires on the cycle whose incremented count would reach TIMEOUT.
  localparam logic [CNT_W-1:0] TmoLast = CNT_W'(TIMEOUT - 1);

  if (TIMEOUT < 2 || 64'(TIMEOUT) > ((64'd1 << CNT_W) - 64'd1)) begin : gen_bad_timeout
    $error("pwm_capture: TIMEOUT out of range");
  end
  if (FILTER_LEN < 1) begin : gen_bad_filter_len
    $error("pwm_capture: FILTER_LEN must be at least 1");
  end

  logic sync1_q, sync2_q;
  logic s, s_d_q;
  logic rise, fall;

  // Two-flop synchronizer for the asynchronous PWM input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_CAP_FILTER_EN
  localparam int unsigned FcW = $clog2(FILTER_LEN + 1);

  logic           filt_q;
  logic [FcW-1:0] fcnt_q;

  // Filtered level follows the raw level only after FILTER_LEN consecutive differing cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else if (sync2_q == filt_q) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FcW'(FILTER_LEN - 1)) begin
      filt_q <= sync2_q;
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + FcW'(1);
    end
  end

  assign s = filt_q;
`else
  assign s = sync2_q;
`endif

  // Delayed level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d_q <= 1'b0;
    end else begin
      s_d_q <= s;
    end
  end

  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             stuck_q, stuck_d;
  logic             level_q, level_d;
  logic             valid_q, valid_d;
  logic             tmo;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CNT_W'(1);
  // Compare with >= so a fall landing on the last count still times out in LOW next cycle.
  assign tmo     = (cnt_q >= TmoLast);

  // Next-state, counter and report logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_lat_d = hi_lat_q;
    period_d = period_q;
    high_d   = high_q;
    stuck_d  = stuck_q;
    level_d  = level_q;
    valid_d  = 1'b0;
    if (!en) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StArm;
          cnt_d   = '0;
        end
        StArm: begin
          if (rise) begin
            state_d = StHigh;
            cnt_d   = CNT_W'(1);
          end else if (tmo) begin
            state_d  = StArm;
            cnt_d    = '0;
            period_d = '0;
            high_d   = '0;
            stuck_d  = 1'b1;
            level_d  = s;
            valid_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StHigh: begin
          if (fall) begin
            hi_lat_d = cnt_q;
            state_d  = StLow;
            cnt_d    = cnt_inc;
          end else if (rise) begin
            // Missed fall: treat as fall + rise, so the high time equals the period.
            hi_lat_d = cnt_q;
            period_d = cnt_q;
            high_d   = cnt_q;
            stuck_d  = 1'b0;
            valid_d  = 1'b1;
            state_d  = StHigh;
            cnt_d    = CNT_W'(1);
          end else if (tmo) begin
            state_d  = StArm;
            cnt_d    = '0;
            period_d = '0;
            high_d   = '0;
            stuck_d  = 1'b1;
            level_d  = s;
            valid_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StLow: begin
          if (rise) begin
            period_d = cnt_q;
            high_d   = hi_lat_q;
            stuck_d  = 1'b0;
            valid_d  = 1'b1;
            state_d  = StHigh;
            cnt_d    = CNT_W'(1);
          end else if (tmo) begin
            state_d  = StArm;
            cnt_d    = '0;
            period_d = '0;
            high_d   = '0;
            stuck_d  = 1'b1;
            level_d  = s;
            valid_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_lat_q <= '0;
      period_q <= '0;
      high_q   <= '0;
      stuck_q  <= 1'b0;
      level_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_lat_q <= hi_lat_d;
      period_q <= period_d;
      high_q   <= high_d;
      stuck_q  <= stuck_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
    end
  end

  assign period      = period_q;
  assign high_time   = high_q;
  assign valid       = valid_q;
  assign stuck       = stuck_q;
  assign stuck_level = level_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: table of PWM segments plus directed corner sequences.
module tb_pwm_capture;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMEOUT = 150;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             stuck;
  logic             stuck_level;
  logic             busy;

  pwm_capture #(
    .CNT_W     (CNT_W),
    .TIMEOUT   (TIMEOUT),
    .FILTER_LEN(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pwm_in     (pwm_in),
    .period     (period),
    .high_time  (high_time),
    .valid      (valid),
    .stuck      (stuck),
    .stuck_level(stuck_level),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hi;
    int lo;
    int nrep;
    int per;
    int ht;
  } vec_t;

  typedef struct {
    int per;
    int ht;
    bit stk;
    bit lvl;
    int cyc;
  } rep_t;

  rep_t reps[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every valid pulse; a pulse longer than one cycle shows up as an extra report.
  always @(negedge clk) begin
    if (valid) begin
      rep_t r;
      r.per = int'(period);
      r.ht  = int'(high_time);
      r.stk = stuck;
      r.lvl = stuck_level;
      r.cyc = cyc;
      reps.push_back(r);
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Hold pwm_in at lvl for n clocks; called just after a rising edge.
  task automatic drive(input bit lvl, input int n);
    pwm_in = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_rep(input string name, input int idx, input int per, input int ht,
                         input bit stk);
    if (idx < reps.size()) begin
      chk({name, "_period"}, reps[idx].per, per);
      chk({name, "_high"}, reps[idx].ht, ht);
      chk({name, "_stuck"}, reps[idx].stk, stk);
    end else begin
      chk({name, "_present"}, reps.size(), idx + 1);
    end
  endtask

  vec_t vecs[10];
  int   exp_p[$];
  int   exp_h[$];

  initial begin
    // Each row: one PWM cycle; a report for the previous row lands inside this row's window.
    vecs[0] = '{25, 75, 0, 0, 0};
    vecs[1] = '{25, 75, 1, 100, 25};
    vecs[2] = '{25, 75, 1, 100, 25};
    vecs[3] = '{75, 25, 1, 100, 25};
    vecs[4] = '{75, 25, 1, 100, 75};
    vecs[5] = '{75, 25, 1, 100, 75};
    vecs[6] = '{10, 30, 1, 100, 75};
    vecs[7] = '{10, 30, 1, 40, 10};
    vecs[8] = '{5, 15, 1, 40, 10};
    vecs[9] = '{5, 15, 1, 20, 5};

    // Reset state.
    #2;
    chk("rst_period", period, 0);
    chk("rst_high", high_time, 0);
    chk("rst_valid", valid, 0);
    chk("rst_stuck", stuck, 0);
    chk("rst_level", stuck_level, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    en = 1'b1;
    drive(1'b0, 10);
    chk("arm_busy", busy, 1);

    // Table-driven steady-state measurements.
    for (int i = 0; i < 10; i++) begin
      reps.delete();
      drive(1'b1, vecs[i].hi);
      drive(1'b0, vecs[i].lo);
      chk($sformatf("vec%0d_count", i), reps.size(), vecs[i].nrep);
      if (vecs[i].nrep > 0) chk_rep($sformatf("vec%0d", i), 0, vecs[i].per, vecs[i].ht, 1'b0);
    end

    // 2-cycle glitch inside the low phase of a 100/25 waveform.
    reps.delete();
    drive(1'b1, 25);
    drive(1'b0, 30);
    drive(1'b1, 2);
    drive(1'b0, 43);
    drive(1'b1, 25);
    drive(1'b0, 75);
    drive(1'b1, 10);
`ifdef PWM_CAP_FILTER_EN
    exp_p = '{20, 100, 100};
    exp_h = '{5, 25, 25};
`else
    exp_p = '{20, 55, 45, 100};
    exp_h = '{5, 25, 2, 25};
`endif
    chk("glitch_count", reps.size(), exp_p.size());
    for (int i = 0; i < exp_p.size(); i++) begin
      chk_rep($sformatf("glitch%0d", i), i, exp_p[i], exp_h[i], 1'b0);
    end

    // Stuck high: rise report, then timeouts TIMEOUT-1 cycles later and every TIMEOUT after.
    reps.delete();
    drive(1'b0, 20);
    drive(1'b1, 330);
    chk("stuckhi_count", reps.size(), 3);
    chk_rep("stuckhi_rise", 0, 30, 10, 1'b0);
    chk_rep("stuckhi_tmo1", 1, 0, 0, 1'b1);
    chk_rep("stuckhi_tmo2", 2, 0, 0, 1'b1);
    if (reps.size() == 3) begin
      chk("stuckhi_level", reps[1].lvl, 1);
      chk("stuckhi_first_gap", reps[1].cyc - reps[0].cyc, TIMEOUT - 1);
      chk("stuckhi_repeat_gap", reps[2].cyc - reps[1].cyc, TIMEOUT);
    end

    // Normal waveform after a timeout clears stuck only after a full cycle.
    reps.delete();
    drive(1'b0, 75);
    drive(1'b1, 25);
    drive(1'b0, 75);
    drive(1'b1, 10);
    chk("recover_count", reps.size(), 1);
    chk_rep("recover", 0, 100, 25, 1'b0);
    chk("recover_stuck_out", stuck, 0);

    // Stuck low.
    reps.delete();
    drive(1'b0, 200);
    chk("stucklo_count", reps.size(), 1);
    chk_rep("stucklo", 0, 0, 0, 1'b1);
    if (reps.size() > 0) chk("stucklo_level", reps[0].lvl, 0);

    // en dropped mid-HIGH, then re-raised.
    reps.delete();
    drive(1'b1, 10);
    chk("endrop_busy_before", busy, 1);
    en = 1'b0;
    drive(1'b1, 1);
    chk("endrop_busy_after", busy, 0);
    drive(1'b1, 14);
    drive(1'b0, 30);
    chk("endrop_no_valid", reps.size(), 0);
    chk("endrop_hold_period", period, 0);
    chk("endrop_hold_stuck", stuck, 1);
    en = 1'b1;
    drive(1'b0, 10);
    drive(1'b1, 25);
    drive(1'b0, 75);
    chk("reen_first_cycle_silent", reps.size(), 0);
    drive(1'b1, 25);
    drive(1'b0, 75);
    drive(1'b1, 10);
    chk("reen_count", reps.size(), 2);
    chk_rep("reen0", 0, 100, 25, 1'b0);
    chk_rep("reen1", 1, 100, 25, 1'b0);

    // Asynchronous reset mid-LOW.
    drive(1'b0, 20);
    chk("prerst_period", period, 100);
    #3;
    rst_n = 1'b0;
    #1;
    chk("asyncrst_period", period, 0);
    chk("asyncrst_high", high_time, 0);
    chk("asyncrst_stuck", stuck, 0);
    chk("asyncrst_busy", busy, 0);
    chk("asyncrst_valid", valid, 0);
    pwm_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("inrst_busy", busy, 0);
    chk("inrst_period", period, 0);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
